// File: rtl/id_operand_stage_pkg.sv
// Shared constants and types for the decode-stage operand/hazard slice.
package id_operand_stage_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NREG     = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_EX,
        FWD_MEM
    } fwd_src_e;

endpackage

// File: rtl/rv_regfile.sv
// Integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, same-cycle bypass of the writeback value.
module rv_regfile
    import id_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = id_operand_stage_pkg::XLEN,
    parameter int unsigned NREG = id_operand_stage_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != REG_ZERO) begin
            regs[wa] <= wd;
        end
    end

    // A register being written this cycle is returned from the write port, never stale.
    assign rd1 = (ra1 == REG_ZERO)       ? '0 :
                 (we && wa == ra1)       ? wd : regs[ra1];
    assign rd2 = (ra2 == REG_ZERO)       ? '0 :
                 (we && wa == ra2)       ? wd : regs[ra2];

endmodule

// File: rtl/id_operand_stage.sv
// Decode operand fetch, EX/MEM forwarding selects and hazard/flush control.
// FORWARD_EN enables EX/MEM forwarding; without it every RAW dependency stalls.
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = id_operand_stage_pkg::XLEN,
    parameter int unsigned NREG = id_operand_stage_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic            ex_rf_we,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_wR,
    input  logic [XLEN-1:0] ex_wD,
    input  logic            mem_rf_we,
    input  logic [4:0]      mem_wR,
    input  logic [XLEN-1:0] mem_wD,
    input  logic            wb_we,
    input  logic [4:0]      wb_wR,
    input  logic [XLEN-1:0] wb_wD,
    input  logic            redirect,
    output logic [XLEN-1:0] rD1,
    output logic [XLEN-1:0] rD2,
    output logic            rD1_op,
    output logic            rD2_op,
    output logic [XLEN-1:0] rD1_forward,
    output logic [XLEN-1:0] rD2_forward,
    output logic            stall,
    output logic            flush_ifid,
    output logic            flush_idex
);

    logic [XLEN-1:0] rf_rd1, rf_rd2;
    logic            ex_m1, ex_m2, mem_m1, mem_m2;
    logic            hazard;
    fwd_src_e        src1, src2;

    rv_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (wb_we),
        .wa    (wb_wR),
        .wd    (wb_wD)
    );

    assign ex_m1  = ex_rf_we  && ex_wR  == rs1 && rs1 != REG_ZERO && rs1_used;
    assign ex_m2  = ex_rf_we  && ex_wR  == rs2 && rs2 != REG_ZERO && rs2_used;
    assign mem_m1 = mem_rf_we && mem_wR == rs1 && rs1 != REG_ZERO && rs1_used;
    assign mem_m2 = mem_rf_we && mem_wR == rs2 && rs2 != REG_ZERO && rs2_used;

`ifdef FORWARD_EN
    // A load in EX blocks its operand entirely: an older MEM value would be stale.
    always_comb begin
        src1   = FWD_NONE;
        src2   = FWD_NONE;
        hazard = ex_is_load && (ex_m1 || ex_m2);
        if (ex_m1 && !ex_is_load) src1 = FWD_EX;
        else if (!ex_m1 && mem_m1) src1 = FWD_MEM;
        if (ex_m2 && !ex_is_load) src2 = FWD_EX;
        else if (!ex_m2 && mem_m2) src2 = FWD_MEM;
    end
`else
    logic unused_load;
    assign unused_load = ex_is_load;
    assign src1   = FWD_NONE;
    assign src2   = FWD_NONE;
    assign hazard = ex_m1 || ex_m2 || mem_m1 || mem_m2;
`endif

    always_comb begin
        rD1         = '0;
        rD2         = '0;
        rD1_op      = 1'b0;
        rD2_op      = 1'b0;
        rD1_forward = '0;
        rD2_forward = '0;
        stall       = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        // Outputs are held at zero throughout reset, even if WB is writing.
        if (rst_n) begin
            rD1 = rf_rd1;
            rD2 = rf_rd2;
            case (src1)
                FWD_EX:  begin rD1_op = 1'b1; rD1_forward = ex_wD;  end
                FWD_MEM: begin rD1_op = 1'b1; rD1_forward = mem_wD; end
                default: ;
            endcase
            case (src2)
                FWD_EX:  begin rD2_op = 1'b1; rD2_forward = ex_wD;  end
                FWD_MEM: begin rD2_op = 1'b1; rD2_forward = mem_wD; end
                default: ;
            endcase
            stall      = hazard && !redirect;
            flush_ifid = redirect;
            flush_idex = hazard || redirect;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: random and directed pipeline states
// checked against a rule-level reference model (honours FORWARD_EN).
module tb_id_operand_stage;

    typedef struct {
        logic        rst_n;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic        ex_we, ex_ld;
        logic [4:0]  ex_wR;
        logic [31:0] ex_wD;
        logic        mem_we;
        logic [4:0]  mem_wR;
        logic [31:0] mem_wD;
        logic        wb_we;
        logic [4:0]  wb_wR;
        logic [31:0] wb_wD;
        logic        redirect;
    } stim_t;

    typedef struct {
        logic [31:0] rD1, rD2, f1, f2;
        logic        op1, op2, stall, fifd, fidx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0;
    logic        rs1_used = 1'b0, rs2_used = 1'b0;
    logic        ex_rf_we = 1'b0, ex_is_load = 1'b0;
    logic [4:0]  ex_wR = '0;
    logic [31:0] ex_wD = '0;
    logic        mem_rf_we = 1'b0;
    logic [4:0]  mem_wR = '0;
    logic [31:0] mem_wD = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_wR = '0;
    logic [31:0] wb_wD = '0;
    logic        redirect = 1'b0;
    logic [31:0] rD1, rD2, rD1_forward, rD2_forward;
    logic        rD1_op, rD2_op, stall, flush_ifid, flush_idex;

    int unsigned total = 0;
    int unsigned bad = 0;
    exp_t        sb[$];
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .ex_rf_we    (ex_rf_we),
        .ex_is_load  (ex_is_load),
        .ex_wR       (ex_wR),
        .ex_wD       (ex_wD),
        .mem_rf_we   (mem_rf_we),
        .mem_wR      (mem_wR),
        .mem_wD      (mem_wD),
        .wb_we       (wb_we),
        .wb_wR       (wb_wR),
        .wb_wD       (wb_wD),
        .redirect    (redirect),
        .rD1         (rD1),
        .rD2         (rD2),
        .rD1_op      (rD1_op),
        .rD2_op      (rD2_op),
        .rD1_forward (rD1_forward),
        .rD2_forward (rD2_forward),
        .stall       (stall),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex)
    );

    // Architectural value of a source register as seen by ID this cycle.
    function automatic logic [31:0] read_reg(input logic [4:0] r, input stim_t s);
        if (r == 5'd0) return 32'd0;
        if (s.wb_we && s.wb_wR == r) return s.wb_wD;
        return rf[r];
    endfunction

    function automatic void operand_rule(input logic [4:0] r, input logic used, input stim_t s,
                                         output logic op, output logic [31:0] v, output logic haz);
        logic in_ex, in_mem;
        in_ex  = used && r != 5'd0 && s.ex_we  && s.ex_wR  == r;
        in_mem = used && r != 5'd0 && s.mem_we && s.mem_wR == r;
        op = 1'b0; v = 32'd0; haz = 1'b0;
`ifdef FORWARD_EN
        if (in_ex && s.ex_ld) haz = 1'b1;
        else if (in_ex) begin op = 1'b1; v = s.ex_wD; end
        else if (in_mem) begin op = 1'b1; v = s.mem_wD; end
`else
        haz = in_ex || in_mem;
`endif
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        logic h1, h2;
        e = '{default: '0};
        if (!s.rst_n) return e;
        e.rD1 = read_reg(s.rs1, s);
        e.rD2 = read_reg(s.rs2, s);
        operand_rule(s.rs1, s.u1, s, e.op1, e.f1, h1);
        operand_rule(s.rs2, s.u2, s, e.op2, e.f2, h2);
        e.stall = (h1 || h2) && !s.redirect;
        e.fifd  = s.redirect;
        e.fidx  = h1 || h2 || s.redirect;
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n    = ($urandom_range(0, 99) != 0);
        s.rs1      = 5'($urandom_range(0, 7));
        s.rs2      = 5'($urandom_range(0, 7));
        s.u1       = ($urandom_range(0, 3) != 0);
        s.u2       = ($urandom_range(0, 3) != 0);
        s.ex_we    = $urandom_range(0, 1) == 1;
        s.ex_ld    = ($urandom_range(0, 3) == 0);
        s.ex_wR    = 5'($urandom_range(0, 7));
        s.ex_wD    = $urandom;
        s.mem_we   = $urandom_range(0, 1) == 1;
        s.mem_wR   = 5'($urandom_range(0, 7));
        s.mem_wD   = $urandom;
        s.wb_we    = ($urandom_range(0, 3) != 0);
        s.wb_wR    = 5'($urandom_range(0, 7));
        s.wb_wD    = $urandom;
        s.redirect = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        rst_n = s.rst_n; rs1 = s.rs1; rs2 = s.rs2; rs1_used = s.u1; rs2_used = s.u2;
        ex_rf_we = s.ex_we; ex_is_load = s.ex_ld; ex_wR = s.ex_wR; ex_wD = s.ex_wD;
        mem_rf_we = s.mem_we; mem_wR = s.mem_wR; mem_wD = s.mem_wD;
        wb_we = s.wb_we; wb_wR = s.wb_wR; wb_wD = s.wb_wD; redirect = s.redirect;
        sb.push_back(model(s));
        if (!s.rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        end else if (s.wb_we && s.wb_wR != 5'd0) begin
            rf[s.wb_wR] = s.wb_wD;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rD1", rD1, e.rD1);
                chk("rD2", rD2, e.rD2);
                chk("rD1_op", {31'd0, rD1_op}, {31'd0, e.op1});
                chk("rD2_op", {31'd0, rD2_op}, {31'd0, e.op2});
                chk("rD1_forward", rD1_forward, e.f1);
                chk("rD2_forward", rD2_forward, e.f2);
                chk("stall", {31'd0, stall}, {31'd0, e.stall});
                chk("flush_ifid", {31'd0, flush_ifid}, {31'd0, e.fifd});
                chk("flush_idex", {31'd0, flush_idex}, {31'd0, e.fidx});
            end
        end
    end

    initial begin : driver
        stim_t s;
        int    waited;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;

        // Reset with WB active: outputs must stay zero.
        s = rand_stim(); s.rst_n = 1'b0; s.wb_we = 1'b1; s.wb_wR = 5'd3; s.rs1 = 5'd3; s.u1 = 1'b1;
        apply(s);
        s = idle(); s.rst_n = 1'b0; apply(s);

        // WB write of x5 read in the same cycle, then from the RF.
        s = idle(); s.wb_we = 1'b1; s.wb_wR = 5'd5; s.wb_wD = 32'h1234; s.rs1 = 5'd5; s.u1 = 1'b1;
        apply(s);
        s = idle(); s.rs1 = 5'd5; s.u1 = 1'b1; apply(s);

        // EX and MEM both write x3: youngest (EX) wins.
        s = idle(); s.ex_we = 1'b1; s.ex_wR = 5'd3; s.ex_wD = 32'hA;
        s.mem_we = 1'b1; s.mem_wR = 5'd3; s.mem_wD = 32'hB; s.rs2 = 5'd3; s.u2 = 1'b1;
        apply(s);
        s.u2 = 1'b0; apply(s);

        // Load-use on x7, then the load in MEM.
        s = idle(); s.ex_we = 1'b1; s.ex_ld = 1'b1; s.ex_wR = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b1;
        apply(s);
        s = idle(); s.mem_we = 1'b1; s.mem_wR = 5'd7; s.mem_wD = 32'h55; s.rs1 = 5'd7; s.u1 = 1'b1;
        apply(s);

        // Load-use together with redirect.
        s = idle(); s.ex_we = 1'b1; s.ex_ld = 1'b1; s.ex_wR = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b1;
        s.redirect = 1'b1;
        apply(s);

        // x0 writes and matches are ignored.
        s = idle(); s.wb_we = 1'b1; s.wb_wR = 5'd0; s.wb_wD = 32'hFFFF;
        s.ex_we = 1'b1; s.ex_wR = 5'd0; s.ex_wD = 32'h77; s.rs1 = 5'd0; s.u1 = 1'b1;
        apply(s);
        s = idle(); s.rs1 = 5'd0; s.u1 = 1'b1; apply(s);

        // ALU producer of x4 walking EX -> MEM -> WB while ID reads x4.
        s = idle(); s.ex_we = 1'b1; s.ex_wR = 5'd4; s.ex_wD = 32'hC0DE; s.rs1 = 5'd4; s.u1 = 1'b1;
        apply(s);
        s = idle(); s.mem_we = 1'b1; s.mem_wR = 5'd4; s.mem_wD = 32'hC0DE; s.rs1 = 5'd4; s.u1 = 1'b1;
        apply(s);
        s = idle(); s.wb_we = 1'b1; s.wb_wR = 5'd4; s.wb_wD = 32'hC0DE; s.rs1 = 5'd4; s.u1 = 1'b1;
        apply(s);

        for (int n = 0; n < 600; n++) apply(rand_stim());

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #1;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Operand/hazard half of the decode stage; sits between the IF/ID register and the ID/EX register.
- Holds the 32x32 integer register file, with write-through bypass from writeback.
- Produces rD1/rD2 plus forwarding selects and values (rD1_op, rD2_op, rD1_forward, rD2_forward) for the ID/EX register.
- Generates load-use stall and the flush controls for IF/ID and ID/EX.
- Instruction decode (alu_op, imm, etc.) stays in a separate decoder; this block only consumes rs1/rs2/rd fields and "used" flags.

Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers (x0 hardwired zero)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rs1  in  5  source register 1 index from IF/ID instruction
- rs2  in  5  source register 2 index
- rs1_used  in  1  instruction reads rs1
- rs2_used  in  1  instruction reads rs2
- ex_rf_we  in  1  instruction in EX writes RF
- ex_is_load  in  1  instruction in EX is a load
- ex_wR  in  5  EX destination
- ex_wD  in  XLEN  EX result (ALU/pc4/imm; not valid for loads)
- mem_rf_we  in  1  instruction in MEM writes RF
- mem_wR  in  5  MEM destination
- mem_wD  in  XLEN  MEM final write data (includes load data)
- wb_we  in  1  writeback enable
- wb_wR  in  5  writeback destination
- wb_wD  in  XLEN  writeback data
- redirect  in  1  branch taken / jump resolved in EX
- rD1  out  XLEN  RF read of rs1 with WB bypass
- rD2  out  XLEN  RF read of rs2 with WB bypass
- rD1_op  out  1  select rD1_forward in ID/EX
- rD2_op  out  1  select rD2_forward in ID/EX
- rD1_forward  out  XLEN  forwarded rs1 value
- rD2_forward  out  XLEN  forwarded rs2 value
- stall  out  1  hold PC and IF/ID
- flush_ifid  out  1  clear IF/ID
- flush_idex  out  1  insert bubble in ID/EX

Behaviour:
- Reset: all registers x1..x31 cleared to 0 asynchronously. Every output is combinational from register state and inputs, so while rst_n is low: rD1/rD2 = 0, forwards = 0, op/stall/flush = 0.
- RF write: on posedge clk when wb_we and wb_wR != 0; writes to x0 are ignored. Reads are combinational.
- WB bypass: if wb_we, wb_wR != 0 and wb_wR == rsN, then rDN = wb_wD (same cycle).
- Reads of x0 always return 0, and x0 never matches for forwarding or hazards.
- Forward match: EXmatchN = ex_rf_we & ex_wR == rsN & rsN != 0 & rsN_used; MEMmatchN is defined the same way on the mem_* inputs.
- Forward priority: EX over MEM (youngest wins).
  - EXmatchN & ~ex_is_load: rDN_op = 1, rDN_forward = ex_wD.
  - Else MEMmatchN: rDN_op = 1, rDN_forward = mem_wD.
  - Else rDN_op = 0, rDN_forward = 0.
- Load-use: if EXmatchN & ex_is_load for either operand, then stall = 1 and flush_idex = 1 (bubble). rDN_op for that operand is 0, since the next cycle's MEM match supplies the data.
- Redirect: flush_ifid = 1 and flush_idex = 1, stall = 0. Redirect overrides a simultaneous load-use stall, because the stalled instruction is on the wrong path.
- Simultaneous WB write and ID read of the same register: the bypassed value is returned, never stale data.
- Forwarding through a stall: rD1_op/rD2_op are sampled by ID/EX even when it is being flushed, so the select values must remain correct while flush_idex is asserted.

Optional Feature:
- Macro FORWARD_EN.
- Defined: EX/MEM forwarding as above; only load-use stalls.
- Undefined: rD1_op = rD2_op = 0 and forwards = 0. Any EXmatch or MEMmatch (load or not) asserts stall = 1 and flush_idex = 1 until the producer reaches WB, where the RF bypass resolves it. Redirect priority is unchanged.

Decomposition:
- Shared package constants: XLEN, NREG, REG_ZERO = 5'd0.
- One natural sub-module, rv_regfile: 2 read ports, 1 write port, async reset, x0 hardwired, WB bypass.
- Hazard/forward logic stays in id_operand_stage.

Test Plan:
- WB writes x5 = 0x1234 while ID reads rs1 = 5 in the same cycle -> rD1 = 0x1234 in that cycle; after the clock edge the RF holds 0x1234.
- EX writes x3 = 0xA (non-load) and MEM writes x3 = 0xB; ID reads rs2 = 3 -> rD2_op = 1, rD2_forward = 0xA.
- EX is a load to x7 and ID uses rs1 = 7 -> stall = 1, flush_idex = 1 for exactly one cycle. The next cycle, with the load in MEM and mem_wD = 0x55, gives rD1_op = 1, rD1_forward = 0x55, stall = 0.
- Load-use on x7 together with redirect = 1 -> stall = 0, flush_ifid = 1, flush_idex = 1.
- WB writes x0 = 0xFFFF, and EX has rf_we with ex_wR = 0; ID reads rs1 = 0 -> rD1 = 0, rD1_op = 0, stall = 0.
- Build without FORWARD_EN; EX ALU writes x4 and ID reads x4 -> stall is held for 2 cycles (EX, then MEM), released when the producer is in WB, with rD1 equal to the WB bypass value.
